// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants: fetch/execute/writeback selects, forward
// encodings, controller states and the per-operand forward-select rule.
package pipe_ctrl_pkg;

    localparam int NUM_STAGES = 5;
    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EXE = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    localparam logic [1:0] PC_NEXT   = 2'd0;
    localparam logic [1:0] PC_JUMP   = 2'd1;
    localparam logic [1:0] PC_BRANCH = 2'd2;
    localparam logic [1:0] PC_EPC    = 2'd3;
    localparam logic       EXE_B_RT  = 1'b0;
    localparam logic       EXE_B_IMM = 1'b1;
    localparam logic       WB_ALU    = 1'b0;
    localparam logic       WB_MEM    = 1'b1;

    typedef enum logic [1:0] {
        FROM_REG        = 2'd0,
        FROM_EXE_ALUOUT = 2'd1,
        FROM_MEM_ALUOUT = 2'd2,
        FROM_MEM_DM     = 2'd3
    } fwd_sel_t;

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_TRAP     = 2'd2,
        S_RETURN   = 2'd3
    } ctrl_state_t;

    // A load still in EXE has no data yet, so it never wins the EXE slot.
    function automatic fwd_sel_t fwd_select(
        input logic [4:0] addr,
        input logic [4:0] exe_addr,
        input logic       exe_wen,
        input logic       exe_ren,
        input logic [4:0] mem_addr,
        input logic       mem_wen,
        input logic       mem_ren
    );
        if (addr == 5'd0)
            return FROM_REG;
        if (exe_wen && !exe_ren && addr == exe_addr)
            return FROM_EXE_ALUOUT;
        if (mem_wen && addr == mem_addr)
            return mem_ren ? FROM_MEM_DM : FROM_MEM_ALUOUT;
        return FROM_REG;
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Combinational hazard unit: operand forward selects, load-use detection and
// the store-data source select.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs_addr_id,
    input  logic [4:0] rt_addr_id,
    input  logic       rs_use_id,
    input  logic       rt_use_id,
    input  logic       store_id,
    input  logic [4:0] regw_addr_exe,
    input  logic       wb_wen_exe,
    input  logic       mem_ren_exe,
    input  logic [4:0] regw_addr_mem,
    input  logic       wb_wen_mem,
    input  logic       mem_ren_mem,
    output fwd_sel_t   fwd_a,
    output fwd_sel_t   fwd_b,
    output logic       load_use,
    output logic       mem_fwd_m
);

    logic exe_load, rs_hit, rt_hit;

    always_comb begin
        fwd_a = fwd_select(rs_addr_id, regw_addr_exe, wb_wen_exe, mem_ren_exe,
                           regw_addr_mem, wb_wen_mem, mem_ren_mem);
        fwd_b = fwd_select(rt_addr_id, regw_addr_exe, wb_wen_exe, mem_ren_exe,
                           regw_addr_mem, wb_wen_mem, mem_ren_mem);
        exe_load = mem_ren_exe && (regw_addr_exe != 5'd0);
        rs_hit   = exe_load && (rs_addr_id == regw_addr_exe);
        rt_hit   = exe_load && (rt_addr_id == regw_addr_exe);
        // Store data is not needed until MEM, so it is picked up from WB
        // one stage later instead of stalling.
        load_use  = (rs_hit && rs_use_id) || (rt_hit && rt_use_id && !store_id);
        mem_fwd_m = !(store_id && rt_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stage enables/resets, forwarding, memory-wait stalls,
// interrupt entry/return sequencing and a saturating stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs_addr_id,
    input  logic [4:0]  rt_addr_id,
    input  logic        rs_use_id,
    input  logic        rt_use_id,
    input  logic        store_id,
    input  logic        redirect_id,
    input  logic        eret_id,
    input  logic [4:0]  regw_addr_exe,
    input  logic        wb_wen_exe,
    input  logic        mem_ren_exe,
    input  logic [4:0]  regw_addr_mem,
    input  logic        wb_wen_mem,
    input  logic        mem_ren_mem,
    input  logic        mem_req,
    input  logic        mem_ack,
    input  logic        irq,
    output logic [4:0]  stage_rst,
    output logic [4:0]  stage_en,
    output logic [1:0]  exe_fwd_a_ctrl,
    output logic [1:0]  exe_fwd_b_ctrl,
    output logic        mem_fwd_m,
    output logic        epc_ctrl,
    output logic        epc_save,
    output logic [31:0] stall_cnt
);

    fwd_sel_t    fwd_a, fwd_b;
    logic        load_use, mem_fwd_raw;
    ctrl_state_t state;
    logic        in_handler;
    logic        run_ok, mem_stall, lu_stall, take_irq, take_eret, take_redir;

    hazard_detect u_hazard (
        .rs_addr_id    (rs_addr_id),
        .rt_addr_id    (rt_addr_id),
        .rs_use_id     (rs_use_id),
        .rt_use_id     (rt_use_id),
        .store_id      (store_id),
        .regw_addr_exe (regw_addr_exe),
        .wb_wen_exe    (wb_wen_exe),
        .mem_ren_exe   (mem_ren_exe),
        .regw_addr_mem (regw_addr_mem),
        .wb_wen_mem    (wb_wen_mem),
        .mem_ren_mem   (mem_ren_mem),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .load_use      (load_use),
        .mem_fwd_m     (mem_fwd_raw)
    );

    // The ack cycle of MEM_WAIT is decoded like RUN so hazards and redirects
    // present when the pipeline resumes are honoured on that same edge.
    always_comb begin
        run_ok     = (state == S_RUN) || (state == S_MEM_WAIT);
        mem_stall  = run_ok && !mem_ack && (mem_req || state == S_MEM_WAIT);
        lu_stall   = run_ok && !mem_stall && load_use;
        take_irq   = run_ok && !mem_stall && !load_use && irq && !in_handler;
        take_eret  = run_ok && !mem_stall && !load_use && !take_irq && eret_id;
        take_redir = run_ok && !mem_stall && !load_use && !take_irq && !take_eret
                     && redirect_id;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_RUN;
            in_handler <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            if ((mem_stall || lu_stall) && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            unique case (state)
                S_TRAP, S_RETURN: state <= S_RUN;
                default: begin
                    if (mem_stall) begin
                        state <= S_MEM_WAIT;
                    end else if (take_irq) begin
                        state      <= S_TRAP;
                        in_handler <= 1'b1;
                    end else if (take_eret) begin
                        state      <= S_RETURN;
                        in_handler <= 1'b0;
                    end else begin
                        state <= S_RUN;
                    end
                end
            endcase
        end
    end

    // Outputs follow the current state and ID/EXE/MEM inputs within the cycle;
    // reset overrides them asynchronously.
    always_comb begin
        stage_en       = '1;
        stage_rst      = '0;
        epc_ctrl       = 1'b0;
        epc_save       = 1'b0;
        exe_fwd_a_ctrl = fwd_a;
        exe_fwd_b_ctrl = fwd_b;
        mem_fwd_m      = mem_fwd_raw;
        if (rst) begin
            stage_en       = '0;
            stage_rst      = '1;
            exe_fwd_a_ctrl = FROM_REG;
            exe_fwd_b_ctrl = FROM_REG;
            mem_fwd_m      = 1'b1;
        end else begin
            unique case (state)
                S_TRAP: begin
                    epc_ctrl           = 1'b1;
                    stage_rst[STG_ID]  = 1'b1;
                    stage_rst[STG_EXE] = 1'b1;
                end
                S_RETURN: begin
                    epc_ctrl          = 1'b1;
                    stage_rst[STG_ID] = 1'b1;
                end
                default: begin
                    if (mem_stall) begin
                        stage_en = '0;
                    end else if (lu_stall) begin
                        stage_en[STG_IF]   = 1'b0;
                        stage_en[STG_ID]   = 1'b0;
                        stage_rst[STG_EXE] = 1'b1;
                    end else if (take_irq) begin
                        epc_save = 1'b1;
                    end else if (take_redir) begin
                        stage_rst[STG_ID] = 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized cycles checked
// against a behavioural model of the controller rules.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_addr_id, rt_addr_id, regw_addr_exe, regw_addr_mem;
    logic        rs_use_id, rt_use_id, store_id, redirect_id, eret_id;
    logic        wb_wen_exe, mem_ren_exe, wb_wen_mem, mem_ren_mem;
    logic        mem_req, mem_ack, irq;
    logic [4:0]  stage_rst, stage_en;
    logic [1:0]  exe_fwd_a_ctrl, exe_fwd_b_ctrl;
    logic        mem_fwd_m, epc_ctrl, epc_save;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    bit     m_wait, m_trap, m_ret, m_ih;
    longint m_cnt;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk(clk), .rst(rst),
        .rs_addr_id(rs_addr_id), .rt_addr_id(rt_addr_id),
        .rs_use_id(rs_use_id), .rt_use_id(rt_use_id), .store_id(store_id),
        .redirect_id(redirect_id), .eret_id(eret_id),
        .regw_addr_exe(regw_addr_exe), .wb_wen_exe(wb_wen_exe), .mem_ren_exe(mem_ren_exe),
        .regw_addr_mem(regw_addr_mem), .wb_wen_mem(wb_wen_mem), .mem_ren_mem(mem_ren_mem),
        .mem_req(mem_req), .mem_ack(mem_ack), .irq(irq),
        .stage_rst(stage_rst), .stage_en(stage_en),
        .exe_fwd_a_ctrl(exe_fwd_a_ctrl), .exe_fwd_b_ctrl(exe_fwd_b_ctrl),
        .mem_fwd_m(mem_fwd_m), .epc_ctrl(epc_ctrl), .epc_save(epc_save),
        .stall_cnt(stall_cnt)
    );

    task automatic clear_inputs();
        rs_addr_id = 0; rt_addr_id = 0; regw_addr_exe = 0; regw_addr_mem = 0;
        rs_use_id = 0; rt_use_id = 0; store_id = 0; redirect_id = 0; eret_id = 0;
        wb_wen_exe = 0; mem_ren_exe = 0; wb_wen_mem = 0; mem_ren_mem = 0;
        mem_req = 0; mem_ack = 0; irq = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        rs_addr_id = 3; rt_addr_id = 3; rs_use_id = 1; store_id = 1; irq = 1;
        regw_addr_exe = 3; wb_wen_exe = 1; mem_ren_exe = 1;
        regw_addr_mem = 3; wb_wen_mem = 1;
        tick();
        n_checks++;
        if ({stage_rst, stage_en} !== {5'b11111, 5'b00000})
            $display("FAIL reset_stage: got rst=%b en=%b expected rst=11111 en=00000", stage_rst, stage_en);
        else n_pass++;
        n_checks++;
        if ({exe_fwd_a_ctrl, exe_fwd_b_ctrl, mem_fwd_m} !== 5'b00001)
            $display("FAIL reset_fwd: got a=%0d b=%0d m=%b expected 0 0 1", exe_fwd_a_ctrl, exe_fwd_b_ctrl, mem_fwd_m);
        else n_pass++;
        n_checks++;
        if ({epc_ctrl, epc_save} !== 2'b00 || stall_cnt !== 32'd0)
            $display("FAIL reset_epc_cnt: got epc=%b%b cnt=%0d expected 00 0", epc_ctrl, epc_save, stall_cnt);
        else n_pass++;
        rst = 1'b0;
        clear_inputs();
        #1;
    endtask

    task automatic test_forward();
        do_reset();
        rs_addr_id = 3; rs_use_id = 1; regw_addr_exe = 3; wb_wen_exe = 1;
        #1;
        n_checks++;
        if (exe_fwd_a_ctrl !== 2'd1 || stage_en !== 5'b11111)
            $display("FAIL fwd_exe_alu: got a=%0d en=%b expected 1 11111", exe_fwd_a_ctrl, stage_en);
        else n_pass++;
        mem_ren_exe = 1;
        #1;
        n_checks++;
        if ({stage_en, stage_rst} !== {5'b11100, 5'b00100})
            $display("FAIL load_use_bubble: got en=%b rst=%b expected 11100 00100", stage_en, stage_rst);
        else n_pass++;
        tick();
        regw_addr_exe = 0; wb_wen_exe = 0; mem_ren_exe = 0;
        regw_addr_mem = 3; wb_wen_mem = 1; mem_ren_mem = 1; rt_addr_id = 3;
        #1;
        n_checks++;
        if (exe_fwd_a_ctrl !== 2'd3 || exe_fwd_b_ctrl !== 2'd3 || stall_cnt !== 32'd1 || stage_en !== 5'b11111)
            $display("FAIL fwd_mem_dm: got a=%0d b=%0d cnt=%0d en=%b expected 3 3 1 11111",
                     exe_fwd_a_ctrl, exe_fwd_b_ctrl, stall_cnt, stage_en);
        else n_pass++;
        mem_ren_mem = 0; regw_addr_exe = 3; wb_wen_exe = 1; rs_addr_id = 4; rt_addr_id = 3;
        #1;
        n_checks++;
        if (exe_fwd_b_ctrl !== 2'd1 || exe_fwd_a_ctrl !== 2'd0)
            $display("FAIL fwd_exe_over_mem: got a=%0d b=%0d expected 0 1", exe_fwd_a_ctrl, exe_fwd_b_ctrl);
        else n_pass++;
        wb_wen_exe = 0;
        #1;
        n_checks++;
        if (exe_fwd_b_ctrl !== 2'd2)
            $display("FAIL fwd_mem_alu: got b=%0d expected 2", exe_fwd_b_ctrl);
        else n_pass++;
        rt_addr_id = 0; regw_addr_mem = 0; regw_addr_exe = 0; wb_wen_exe = 1;
        #1;
        n_checks++;
        if (exe_fwd_b_ctrl !== 2'd0)
            $display("FAIL fwd_r0: got b=%0d expected 0", exe_fwd_b_ctrl);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_store_data();
        do_reset();
        store_id = 1; rt_addr_id = 5; rt_use_id = 1;
        regw_addr_exe = 5; wb_wen_exe = 1; mem_ren_exe = 1;
        #1;
        n_checks++;
        if (mem_fwd_m !== 1'b0 || stage_en !== 5'b11111)
            $display("FAIL store_from_wb: got m=%b en=%b expected 0 11111", mem_fwd_m, stage_en);
        else n_pass++;
        rt_addr_id = 0; regw_addr_exe = 0;
        #1;
        n_checks++;
        if (mem_fwd_m !== 1'b1)
            $display("FAIL store_r0: got m=%b expected 1", mem_fwd_m);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1; mem_ack = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({stage_en, stage_rst} !== 10'd0)
                $display("FAIL mem_wait_cycle%0d: got en=%b rst=%b expected 00000 00000", i, stage_en, stage_rst);
            else n_pass++;
            tick();
        end
        mem_ack = 1;
        #1;
        n_checks++;
        if (stage_en !== 5'b11111 || stall_cnt !== 32'd3)
            $display("FAIL mem_wait_ack: got en=%b cnt=%0d expected 11111 3", stage_en, stall_cnt);
        else n_pass++;
        tick();
        clear_inputs();
        #1;
        n_checks++;
        if (stage_en !== 5'b11111 || stall_cnt !== 32'd3)
            $display("FAIL mem_wait_resume: got en=%b cnt=%0d expected 11111 3", stage_en, stall_cnt);
        else n_pass++;
    endtask

    task automatic test_irq_eret();
        do_reset();
        irq = 1;
        #1;
        n_checks++;
        if ({epc_save, epc_ctrl} !== 2'b10 || stage_en !== 5'b11111)
            $display("FAIL irq_save: got save=%b ctrl=%b en=%b expected 1 0 11111", epc_save, epc_ctrl, stage_en);
        else n_pass++;
        tick();
        irq = 0;
        #1;
        n_checks++;
        if ({epc_ctrl, epc_save} !== 2'b10 || stage_rst !== 5'b00110 || stage_en[0] !== 1'b1)
            $display("FAIL trap_cycle: got ctrl=%b save=%b rst=%b en=%b expected 1 0 00110 xxxx1",
                     epc_ctrl, epc_save, stage_rst, stage_en);
        else n_pass++;
        tick();
        irq = 1;
        #1;
        n_checks++;
        if ({epc_ctrl, epc_save} !== 2'b00)
            $display("FAIL irq_in_handler: got ctrl=%b save=%b expected 0 0", epc_ctrl, epc_save);
        else n_pass++;
        tick();
        eret_id = 1;
        #1;
        n_checks++;
        if ({epc_ctrl, epc_save} !== 2'b00)
            $display("FAIL eret_issue: got ctrl=%b save=%b expected 0 0", epc_ctrl, epc_save);
        else n_pass++;
        tick();
        eret_id = 0;
        #1;
        n_checks++;
        if (epc_ctrl !== 1'b1 || stage_rst !== 5'b00010 || epc_save !== 1'b0)
            $display("FAIL return_cycle: got ctrl=%b rst=%b save=%b expected 1 00010 0", epc_ctrl, stage_rst, epc_save);
        else n_pass++;
        tick();
        #1;
        n_checks++;
        if (epc_save !== 1'b1)
            $display("FAIL held_irq_taken: got save=%b expected 1", epc_save);
        else n_pass++;
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_priority();
        do_reset();
        irq = 1; rs_addr_id = 3; rs_use_id = 1;
        regw_addr_exe = 3; wb_wen_exe = 1; mem_ren_exe = 1;
        mem_req = 1; mem_ack = 0;
        #1;
        n_checks++;
        if ({stage_en, stage_rst, epc_save} !== 11'd0)
            $display("FAIL prio_mem_wait: got en=%b rst=%b save=%b expected 00000 00000 0", stage_en, stage_rst, epc_save);
        else n_pass++;
        tick();
        mem_ack = 1;
        #1;
        n_checks++;
        if ({stage_en, stage_rst, epc_save} !== {5'b11100, 5'b00100, 1'b0})
            $display("FAIL prio_load_use: got en=%b rst=%b save=%b expected 11100 00100 0", stage_en, stage_rst, epc_save);
        else n_pass++;
        tick();
        mem_req = 0; mem_ack = 0; wb_wen_exe = 0; mem_ren_exe = 0;
        #1;
        n_checks++;
        if (epc_save !== 1'b1 || stage_en !== 5'b11111 || stall_cnt !== 32'd2)
            $display("FAIL prio_irq: got save=%b en=%b cnt=%0d expected 1 11111 2", epc_save, stage_en, stall_cnt);
        else n_pass++;
        tick();
        irq = 0;
        #1;
        n_checks++;
        if (epc_ctrl !== 1'b1 || stage_rst !== 5'b00110)
            $display("FAIL prio_trap: got ctrl=%b rst=%b expected 1 00110", epc_ctrl, stage_rst);
        else n_pass++;
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_in_trap();
        do_reset();
        rs_addr_id = 3; rs_use_id = 1; regw_addr_exe = 3; wb_wen_exe = 1; mem_ren_exe = 1;
        tick();
        clear_inputs();
        irq = 1;
        tick();
        irq = 0;
        #1;
        n_checks++;
        if (epc_ctrl !== 1'b1 || stall_cnt !== 32'd1)
            $display("FAIL pre_reset_trap: got ctrl=%b cnt=%0d expected 1 1", epc_ctrl, stall_cnt);
        else n_pass++;
        rst = 1;
        #1;
        n_checks++;
        if ({stage_rst, stage_en, epc_ctrl, epc_save} !== {5'b11111, 5'b00000, 2'b00} || stall_cnt !== 32'd0)
            $display("FAIL async_reset_trap: got rst=%b en=%b ctrl=%b save=%b cnt=%0d expected 11111 00000 0 0 0",
                     stage_rst, stage_en, epc_ctrl, epc_save, stall_cnt);
        else n_pass++;
        tick();
        rst = 0;
        #1;
        n_checks++;
        if ({stage_en, stage_rst, epc_ctrl, epc_save} !== {5'b11111, 5'b00000, 2'b00})
            $display("FAIL post_reset_run: got en=%b rst=%b ctrl=%b save=%b expected 11111 00000 0 0",
                     stage_en, stage_rst, epc_ctrl, epc_save);
        else n_pass++;
        irq = 1;
        #1;
        n_checks++;
        if (epc_save !== 1'b1)
            $display("FAIL post_reset_handler_clear: got save=%b expected 1", epc_save);
        else n_pass++;
        tick();
        clear_inputs();
        tick();
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] a);
        if (a == 0) return 2'd0;
        if (wb_wen_exe && !mem_ren_exe && a == regw_addr_exe) return 2'd1;
        if (wb_wen_mem && a == regw_addr_mem) return mem_ren_mem ? 2'd3 : 2'd2;
        return 2'd0;
    endfunction

    task automatic test_random(input int cycles);
        logic [4:0] e_en, e_rst;
        logic       e_ctrl, e_save, e_m, lu, memst, ld;
        logic [1:0] e_a, e_b;
        do_reset();
        m_wait = 0; m_trap = 0; m_ret = 0; m_ih = 0; m_cnt = 0;
        for (int c = 0; c < cycles; c++) begin
            rs_addr_id    = 5'($urandom_range(0, 3));
            rt_addr_id    = 5'($urandom_range(0, 3));
            regw_addr_exe = 5'($urandom_range(0, 3));
            regw_addr_mem = 5'($urandom_range(0, 3));
            rs_use_id     = 1'($urandom_range(0, 1));
            rt_use_id     = 1'($urandom_range(0, 1));
            store_id      = ($urandom_range(0, 3) == 0);
            wb_wen_exe    = 1'($urandom_range(0, 1));
            mem_ren_exe   = wb_wen_exe && ($urandom_range(0, 2) == 0);
            wb_wen_mem    = 1'($urandom_range(0, 1));
            mem_ren_mem   = wb_wen_mem && ($urandom_range(0, 1) == 0);
            redirect_id   = ($urandom_range(0, 3) == 0);
            eret_id       = ($urandom_range(0, 9) == 0);
            irq           = ($urandom_range(0, 5) == 0);
            mem_req       = ($urandom_range(0, 3) == 0);
            mem_ack       = 1'($urandom_range(0, 1));
            #1;
            ld   = mem_ren_exe && regw_addr_exe != 0;
            lu   = ld && ((rs_use_id && rs_addr_id == regw_addr_exe) ||
                          (rt_use_id && !store_id && rt_addr_id == regw_addr_exe));
            e_m  = !(store_id && ld && rt_addr_id == regw_addr_exe);
            e_a  = ref_fwd(rs_addr_id);
            e_b  = ref_fwd(rt_addr_id);
            memst = !m_trap && !m_ret && !mem_ack && (m_wait || mem_req);
            e_en = 5'b11111; e_rst = 5'b00000; e_ctrl = 0; e_save = 0;
            if (m_trap) begin e_ctrl = 1; e_rst = 5'b00110; end
            else if (m_ret) begin e_ctrl = 1; e_rst = 5'b00010; end
            else if (memst) e_en = 5'b00000;
            else if (lu) begin e_en = 5'b11100; e_rst = 5'b00100; end
            else if (irq && !m_ih) e_save = 1;
            else if (eret_id) e_rst = 5'b00000;
            else if (redirect_id) e_rst = 5'b00010;
            n_checks++;
            if ({stage_en, stage_rst, epc_ctrl, epc_save} !== {e_en, e_rst, e_ctrl, e_save})
                $display("FAIL rand_ctrl c%0d: got en=%b rst=%b ctrl=%b save=%b expected %b %b %b %b",
                         c, stage_en, stage_rst, epc_ctrl, epc_save, e_en, e_rst, e_ctrl, e_save);
            else n_pass++;
            n_checks++;
            if ({exe_fwd_a_ctrl, exe_fwd_b_ctrl, mem_fwd_m} !== {e_a, e_b, e_m})
                $display("FAIL rand_fwd c%0d: got a=%0d b=%0d m=%b expected %0d %0d %b",
                         c, exe_fwd_a_ctrl, exe_fwd_b_ctrl, mem_fwd_m, e_a, e_b, e_m);
            else n_pass++;
            n_checks++;
            if (stall_cnt !== 32'(m_cnt))
                $display("FAIL rand_cnt c%0d: got %0d expected %0d", c, stall_cnt, m_cnt);
            else n_pass++;
            if (m_trap || m_ret) begin
                m_trap = 0; m_ret = 0;
            end else if (memst) begin
                m_wait = 1; m_cnt++;
            end else begin
                m_wait = 0;
                if (lu) m_cnt++;
                else if (irq && !m_ih) begin m_trap = 1; m_ih = 1; end
                else if (eret_id) begin m_ret = 1; m_ih = 0; end
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_forward();
        test_store_data();
        test_mem_wait();
        test_irq_eret();
        test_priority();
        test_reset_in_trap();
        test_random(400);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
